// File: rtl/rs485_req_ctrl.sv
// RS485 request/ACK transaction controller: streams ADR, CMD and tx-buffer bytes to the master, then collects and checks the ACK.
// Outputs are registered except txd, which is a mux on registered state; tx advances only on master txd_rd pulses.
module rs485_req_ctrl #(
    parameter int BUF_AW      = 4,
    parameter int TIMEOUT_W   = 20,
    parameter int TIMEOUT_CNT = 640000
) (
    input  logic              p_in_clk,
    input  logic              p_in_rst,
    input  logic              p_in_start,
    input  logic [7:0]        p_in_adr,
    input  logic [7:0]        p_in_cmd,
    input  logic [4:0]        p_in_len,
    input  logic              p_in_txbuf_wr,
    input  logic [BUF_AW-1:0] p_in_txbuf_adr,
    input  logic [7:0]        p_in_txbuf_d,
    input  logic [BUF_AW-1:0] p_in_rxbuf_adr,
    output logic [7:0]        p_out_rxbuf_d,
    output logic [4:0]        p_out_rxlen,
    output logic              p_out_busy,
    output logic              p_out_done,
    output logic [2:0]        p_out_result,
    output logic              p_out_txd_rdy,
    output logic [7:0]        p_out_txd,
    input  logic              p_in_txd_rd,
    input  logic [7:0]        p_in_rxd,
    input  logic              p_in_rxd_wr,
    input  logic [2:0]        p_in_status
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TX   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int                   DEPTH    = 1 << BUF_AW;
    localparam logic [4:0]           LEN_MAX  = 5'(DEPTH);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CNT - 1);

    localparam logic [2:0] RES_OK       = 3'd1;
    localparam logic [2:0] RES_PARITY   = 3'd2;
    localparam logic [2:0] RES_TIMEOUT  = 3'd3;
    localparam logic [2:0] RES_MISMATCH = 3'd4;
    localparam logic [2:0] RES_OVERFLOW = 3'd5;

    logic [7:0] txbuf [DEPTH];
    logic [7:0] rxbuf [DEPTH];

    logic [1:0]           state_q, state_d;
    logic [7:0]           adr_q, adr_d, cmd_q, cmd_d;
    logic [4:0]           total_q, total_d, idx_q, idx_d;
    logic [4:0]           rxcnt_q, rxcnt_d, rxlen_q, rxlen_d;
    logic                 mism_q, mism_d, ovf_q, ovf_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 txd_rdy_q, txd_rdy_d, busy_q, busy_d, done_q, done_d;
    logic [2:0]           result_q, result_d;
    logic [7:0]           rxbuf_d_q;

    logic              rx_store;
    logic [4:0]        len_clamp;
    logic [BUF_AW-1:0] tx_radr;
    logic [7:0]        txd_mux;

    assign len_clamp = (p_in_len > LEN_MAX) ? LEN_MAX : p_in_len;
    assign tx_radr   = BUF_AW'(idx_q - 5'd2);

    // Live read of txbuf: late writes still reach bytes not yet presented.
    always_comb begin
        txd_mux = 8'h00;
        if (state_q == ST_TX) begin
            case (idx_q)
                5'd0:    txd_mux = adr_q;
                5'd1:    txd_mux = cmd_q;
                default: txd_mux = txbuf[tx_radr];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        cmd_d     = cmd_q;
        total_d   = total_q;
        idx_d     = idx_q;
        rxcnt_d   = rxcnt_q;
        rxlen_d   = rxlen_q;
        mism_d    = mism_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        txd_rdy_d = txd_rdy_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        rx_store  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (p_in_start) begin
                    adr_d     = p_in_adr;
                    cmd_d     = p_in_cmd;
                    total_d   = len_clamp + 5'd2;
                    idx_d     = 5'd0;
                    rxcnt_d   = 5'd0;
                    rxlen_d   = 5'd0;
                    mism_d    = 1'b0;
                    ovf_d     = 1'b0;
                    tmo_d     = '0;
                    result_d  = 3'd0;
                    busy_d    = 1'b1;
                    txd_rdy_d = 1'b1;
                    state_d   = ST_TX;
                end
            end
            ST_TX: begin
                if (p_in_txd_rd) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q + 5'd1 == total_q) begin
                        txd_rdy_d = 1'b0;
                        tmo_d     = '0;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (p_in_rxd_wr) begin
                    tmo_d = '0;
                    if (rxcnt_q == 5'd0 && p_in_rxd != adr_q) mism_d = 1'b1;
                    if (rxcnt_q == 5'd1 && p_in_rxd != cmd_q) mism_d = 1'b1;
                    if (rxcnt_q >= 5'd2) begin
                        if (rxlen_q < LEN_MAX) begin
                            rx_store = 1'b1;
                            rxlen_d  = rxlen_q + 5'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    // Saturate so a long babbling slave cannot wrap back below 2.
                    if (rxcnt_q != 5'd31) rxcnt_d = rxcnt_q + 5'd1;
                end
                // A byte arriving with status is folded in via the _d flags.
                if (p_in_status != 3'd0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (p_in_status == 3'd2)            result_d = RES_PARITY;
                    else if (rxcnt_d < 5'd2 || mism_d)  result_d = RES_MISMATCH;
                    else if (ovf_d)                     result_d = RES_OVERFLOW;
                    else                                result_d = RES_OK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = RES_TIMEOUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge p_in_clk or posedge p_in_rst) begin
        if (p_in_rst) begin
            state_q   <= ST_IDLE;
            adr_q     <= 8'h00;
            cmd_q     <= 8'h00;
            total_q   <= 5'd0;
            idx_q     <= 5'd0;
            rxcnt_q   <= 5'd0;
            rxlen_q   <= 5'd0;
            mism_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= '0;
            txd_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 3'd0;
            rxbuf_d_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            cmd_q     <= cmd_d;
            total_q   <= total_d;
            idx_q     <= idx_d;
            rxcnt_q   <= rxcnt_d;
            rxlen_q   <= rxlen_d;
            mism_q    <= mism_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            txd_rdy_q <= txd_rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rxbuf_d_q <= rxbuf[p_in_rxbuf_adr];
        end
    end

    always_ff @(posedge p_in_clk) begin
        if (p_in_txbuf_wr) txbuf[p_in_txbuf_adr] <= p_in_txbuf_d;
    end

    always_ff @(posedge p_in_clk) begin
        if (rx_store) rxbuf[BUF_AW'(rxlen_q)] <= p_in_rxd;
    end

    assign p_out_rxbuf_d = rxbuf_d_q;
    assign p_out_rxlen   = rxlen_q;
    assign p_out_busy    = busy_q;
    assign p_out_done    = done_q;
    assign p_out_result  = result_q;
    assign p_out_txd_rdy = txd_rdy_q;
    assign p_out_txd     = txd_mux;

endmodule

// File: tb/tb_rs485_req_ctrl.sv
// Directed bench for rs485_req_ctrl: a transaction table plus hand-written timeout, busy-start and mid-TX reset sequences.
module tb_rs485_req_ctrl;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] adr, cmd;
    logic [4:0] len;
    logic       txbuf_wr;
    logic [3:0] txbuf_adr;
    logic [7:0] txbuf_d;
    logic [3:0] rxbuf_adr;
    logic [7:0] rxbuf_d;
    logic [4:0] rxlen;
    logic       busy, done;
    logic [2:0] result;
    logic       txd_rdy;
    logic [7:0] txd;
    logic       txd_rd;
    logic [7:0] rxd;
    logic       rxd_wr;
    logic [2:0] status;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] txpat [16];

    typedef struct {
        logic [7:0] adr;
        logic [7:0] cmd;
        logic [4:0] len;
        int         n_ack;
        logic [7:0] first;
        logic [2:0] status;
        logic [2:0] exp_res;
        logic [4:0] exp_rxlen;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    rs485_req_ctrl #(
        .BUF_AW      (4),
        .TIMEOUT_W   (20),
        .TIMEOUT_CNT (TMO)
    ) dut (
        .p_in_clk       (clk),
        .p_in_rst       (rst),
        .p_in_start     (start),
        .p_in_adr       (adr),
        .p_in_cmd       (cmd),
        .p_in_len       (len),
        .p_in_txbuf_wr  (txbuf_wr),
        .p_in_txbuf_adr (txbuf_adr),
        .p_in_txbuf_d   (txbuf_d),
        .p_in_rxbuf_adr (rxbuf_adr),
        .p_out_rxbuf_d  (rxbuf_d),
        .p_out_rxlen    (rxlen),
        .p_out_busy     (busy),
        .p_out_done     (done),
        .p_out_result   (result),
        .p_out_txd_rdy  (txd_rdy),
        .p_out_txd      (txd),
        .p_in_txd_rd    (txd_rd),
        .p_in_rxd       (rxd),
        .p_in_rxd_wr    (rxd_wr),
        .p_in_status    (status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rx_pat(input int j);
        return 8'(8'h55 * (j + 1));
    endfunction

    function automatic logic [7:0] tx_exp(input int k, input logic [7:0] a, input logic [7:0] c);
        if (k == 0) return a;
        if (k == 1) return c;
        return txpat[k - 2];
    endfunction

    task automatic start_txn(input logic [7:0] a, input logic [7:0] c, input logic [4:0] l);
        adr   = a;
        cmd   = c;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("result_cleared", result, 0);
    endtask

    task automatic do_tx(input logic [7:0] a, input logic [7:0] c, input int total);
        for (int k = 0; k < total; k++) begin
            check("txd_rdy", txd_rdy, 1);
            check("txd", txd, tx_exp(k, a, c));
            tick();
            check("txd_hold", txd, tx_exp(k, a, c));
            txd_rd = 1'b1;
            tick();
            txd_rd = 1'b0;
        end
        check("txd_rdy_off", txd_rdy, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxd    = b;
        rxd_wr = 1'b1;
        tick();
        rxd_wr = 1'b0;
        tick();
    endtask

    task automatic finish_txn(input logic [2:0] s, input logic [2:0] exp_res, input logic [4:0] exp_rxlen);
        status = s;
        tick();
        status = 3'd0;
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("result", result, exp_res);
        tick();
        check("done_one_clk", done, 0);
        check("rxlen", rxlen, exp_rxlen);
        for (int j = 0; j < int'(exp_rxlen); j++) begin
            rxbuf_adr = 4'(j);
            tick();
            check("rxbuf", rxbuf_d, rx_pat(j));
        end
    endtask

    initial begin
        int cyc;
        int total;

        vecs[0] = '{8'h12, 8'h81, 5'd2,  4,  8'h12, 3'd1, 3'd1, 5'd2};
        vecs[1] = '{8'h12, 8'h81, 5'd2,  1,  8'h12, 3'd2, 3'd2, 5'd0};
        vecs[2] = '{8'h12, 8'h81, 5'd2,  4,  8'h13, 3'd1, 3'd4, 5'd2};
        vecs[3] = '{8'h5A, 8'hC3, 5'd16, 20, 8'h5A, 3'd1, 3'd5, 5'd16};
        vecs[4] = '{8'h07, 8'h02, 5'd0,  2,  8'h07, 3'd1, 3'd1, 5'd0};
        vecs[5] = '{8'h33, 8'h44, 5'd20, 3,  8'h33, 3'd1, 3'd1, 5'd1};
        vecs[6] = '{8'h33, 8'h44, 5'd3,  1,  8'h33, 3'd1, 3'd4, 5'd0};

        txpat[0] = 8'hA5;
        txpat[1] = 8'h3C;
        for (int k = 2; k < 16; k++) txpat[k] = 8'(k * 17 + 3);

        rst = 1'b1; start = 1'b0; adr = 8'h00; cmd = 8'h00; len = 5'd0;
        txbuf_wr = 1'b0; txbuf_adr = 4'd0; txbuf_d = 8'h00; rxbuf_adr = 4'd0;
        txd_rd = 1'b0; rxd = 8'h00; rxd_wr = 1'b0; status = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_txd_rdy", txd_rdy, 0);
        check("rst_txd", txd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_rxlen", rxlen, 0);
        check("rst_rxbuf_d", rxbuf_d, 0);

        for (int k = 0; k < 16; k++) begin
            txbuf_wr  = 1'b1;
            txbuf_adr = 4'(k);
            txbuf_d   = txpat[k];
            tick();
        end
        txbuf_wr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            total = ((vecs[i].len > 5'd16) ? 16 : int'(vecs[i].len)) + 2;
            start_txn(vecs[i].adr, vecs[i].cmd, vecs[i].len);
            do_tx(vecs[i].adr, vecs[i].cmd, total);
            for (int j = 0; j < vecs[i].n_ack; j++) begin
                if (j == 0)      send_byte(vecs[i].first);
                else if (j == 1) send_byte(vecs[i].cmd);
                else             send_byte(rx_pat(j - 2));
            end
            finish_txn(vecs[i].status, vecs[i].exp_res, vecs[i].exp_rxlen);
        end

        // Silence after the last request byte must time out exactly TMO clocks after the final rd.
        start_txn(8'h12, 8'h81, 5'd1);
        do_tx(8'h12, 8'h81, 3);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("tmo_cycles", cyc, TMO);
        check("tmo_result", result, 3);
        check("tmo_rxlen", rxlen, 0);
        tick();
        check("tmo_done_clr", done, 0);

        // Start pulses while busy are ignored, as are ACK bytes arriving during TX.
        start_txn(8'h21, 8'h22, 5'd0);
        adr   = 8'h99;
        cmd   = 8'h98;
        len   = 5'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h21);
        do_tx(8'h21, 8'h22, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_wait", busy, 1);
        send_byte(8'h21);
        send_byte(8'h22);
        finish_txn(3'd1, 3'd1, 5'd0);
        tick();
        check("no_restart", busy, 0);

        // Asynchronous reset in the middle of TX.
        start_txn(8'h12, 8'h81, 5'd2);
        txd_rd = 1'b1;
        tick();
        txd_rd = 1'b0;
        check("tx_before_rst", txd, 8'h81);
        rst = 1'b1;
        #1;
        check("arst_txd_rdy", txd_rdy, 0);
        check("arst_busy", busy, 0);
        check("arst_txd", txd, 0);
        check("arst_result", result, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_done_after_rst", done, 0);
        end
        check("idle_after_rst", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
